// File: rtl/osc_wake_pkg.sv
// Shared types and defaults for the oscillator / wake controller.
package osc_wake_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD = 3'd0,
    ST_WARMUP   = 3'd1,
    ST_RUN      = 3'd2,
    ST_HALT     = 3'd3,
    ST_STOP     = 3'd4
  } state_e;

  localparam int unsigned RST_HOLD_DEF      = 4;
  localparam int unsigned STABLE_CYCLES_DEF = 16;
  localparam int unsigned NIRQ_DEF          = 5;

  // Counter width sized for the longer of the two timed phases, never zero.
  function automatic int unsigned cnt_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return ($clog2(m) > 0) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/osc_wake_if.sv
// Sequencer-facing bundle: HALT/STOP requests and interrupt/joypad inputs in,
// reset/stable/wake/clock-gate indications out.
interface osc_wake_if #(parameter int unsigned NIRQ = 5);
  logic            CLK_ENA;
  logic            OSC_ENA;
  logic [NIRQ-1:0] IRQ_PEND;
  logic [NIRQ-1:0] IE;
  logic [3:0]      JOYP_N;
  logic            SYNC_RESET;
  logic            OSC_STABLE;
  logic            WAKE;
  logic            CPU_CLK_GATE;
  logic [2:0]      STATE;

  modport master (
    output CLK_ENA, OSC_ENA, IRQ_PEND, IE, JOYP_N,
    input  SYNC_RESET, OSC_STABLE, WAKE, CPU_CLK_GATE, STATE
  );

  modport slave (
    input  CLK_ENA, OSC_ENA, IRQ_PEND, IE, JOYP_N,
    output SYNC_RESET, OSC_STABLE, WAKE, CPU_CLK_GATE, STATE
  );
endinterface

// File: rtl/osc_wake_sync.sv
// N-bit two-flop synchroniser; resets to all-ones so idle active-low lines stay inactive.
module osc_wake_sync #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/osc_wake_ctrl.sv
// Clock/reset responder for the CPU sequencer: reset hold, oscillator warm-up,
// HALT/STOP handling with wake pulses, and CPU clock gating.
module osc_wake_ctrl
  import osc_wake_pkg::*;
#(
  parameter int unsigned RST_HOLD      = RST_HOLD_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned NIRQ          = NIRQ_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  osc_wake_if.slave  bus
);
  localparam int unsigned CW      = cnt_w(RST_HOLD, STABLE_CYCLES);
  localparam logic [CW-1:0] HOLD_LD = CW'(RST_HOLD - 1);
  localparam logic [CW-1:0] WARM_LD = CW'(STABLE_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sync_reset_q, sync_reset_d;
  logic            osc_stable_q, osc_stable_d;
  logic            wake_q, wake_d;
  logic            gate_q, gate_d;
  logic [3:0]      joy_s;
  logic [NIRQ-1:0] irq_en;
  logic            wake_irq, wake_stop;

  osc_wake_sync #(.W(4)) u_joy_sync (
    .clk (CLK),
    .rst (RESET),
    .d_i (bus.JOYP_N),
    .q_o (joy_s)
  );

  assign irq_en    = bus.IRQ_PEND & bus.IE;
  assign wake_irq  = |irq_en;
  assign wake_stop = ~&joy_s | wake_irq;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    wake_d  = 1'b0;
    case (state_q)
      ST_RST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_WARMUP;
          cnt_d   = WARM_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_WARMUP: begin
        // A still-set SYNC_RESET marks the power-up warm-up, which always ends in RUN.
        if (cnt_q == '0) state_d = (sync_reset_q || bus.OSC_ENA) ? ST_RUN : ST_STOP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_RUN: begin
        if (!bus.OSC_ENA)      state_d = ST_STOP;
        else if (!bus.CLK_ENA) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (!bus.OSC_ENA) state_d = ST_STOP;
        else if (wake_irq) begin
          state_d = ST_RUN;
          wake_d  = 1'b1;
        end else if (bus.CLK_ENA) state_d = ST_RUN;
      end
      ST_STOP: begin
        if (wake_stop) begin
          state_d = ST_WARMUP;
          cnt_d   = WARM_LD;
          wake_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_RST_HOLD;
        cnt_d   = HOLD_LD;
      end
    endcase
    sync_reset_d = (state_d == ST_RST_HOLD) || (sync_reset_q && state_d != ST_RUN);
    osc_stable_d = (state_d == ST_RUN) || (state_d == ST_HALT);
    gate_d       = (state_d == ST_RUN);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_RST_HOLD;
      cnt_q        <= HOLD_LD;
      sync_reset_q <= 1'b1;
      osc_stable_q <= 1'b0;
      wake_q       <= 1'b0;
      gate_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync_reset_q <= sync_reset_d;
      osc_stable_q <= osc_stable_d;
      wake_q       <= wake_d;
      gate_q       <= gate_d;
    end
  end

  assign bus.SYNC_RESET   = sync_reset_q;
  assign bus.OSC_STABLE   = osc_stable_q;
  assign bus.WAKE         = wake_q;
  assign bus.CPU_CLK_GATE = gate_q;
  assign bus.STATE        = state_q;
endmodule

// File: tb/tb_osc_wake_ctrl.sv
// Bench for osc_wake_ctrl: directed scenarios plus random traffic against a cycle model.
module tb_osc_wake_ctrl;
  localparam int RH = 4;
  localparam int SC = 16;
  localparam int P_HOLD = 0, P_WARM = 1, P_RUN = 2, P_HALT = 3, P_STOP = 4;

  logic clk, rst;
  int   n_vec, n_err, wake_cnt, n, w0;
  bit   chk_on;

  osc_wake_if #(.NIRQ(5)) bus ();

  osc_wake_ctrl #(.RST_HOLD(RH), .STABLE_CYCLES(SC), .NIRQ(5)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: mode plus cycles-remaining timer, joypad seen through a 2-deep delay line.
  int         m_mode, m_rem;
  bit         m_boot, m_wake, m_irq;
  logic [3:0] m_hist [0:1];
  logic [3:0] m_joy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = P_HOLD; m_rem = RH; m_boot = 1; m_wake = 0;
      m_hist[0] = 4'hF; m_hist[1] = 4'hF;
    end else begin
      m_joy = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = bus.JOYP_N;
      m_irq  = (bus.IRQ_PEND & bus.IE) != 0;
      m_wake = 0;
      case (m_mode)
        P_HOLD: begin
          m_rem--;
          if (m_rem == 0) begin m_mode = P_WARM; m_rem = SC; end
        end
        P_WARM: begin
          m_rem--;
          if (m_rem == 0) begin
            if (m_boot || bus.OSC_ENA) begin m_mode = P_RUN; m_boot = 0; end
            else m_mode = P_STOP;
          end
        end
        P_RUN: begin
          if (!bus.OSC_ENA) m_mode = P_STOP;
          else if (!bus.CLK_ENA) m_mode = P_HALT;
        end
        P_HALT: begin
          if (!bus.OSC_ENA) m_mode = P_STOP;
          else if (m_irq) begin m_mode = P_RUN; m_wake = 1; end
          else if (bus.CLK_ENA) m_mode = P_RUN;
        end
        default: begin
          if (m_joy != 4'hF || m_irq) begin m_mode = P_WARM; m_rem = SC; m_wake = 1; end
        end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("STATE",        32'(bus.STATE), 32'(m_mode));
      chk("SYNC_RESET",   32'(bus.SYNC_RESET), 32'(m_boot));
      chk("OSC_STABLE",   32'(bus.OSC_STABLE), 32'(m_mode == P_RUN || m_mode == P_HALT));
      chk("CPU_CLK_GATE", 32'(bus.CPU_CLK_GATE), 32'(m_mode == P_RUN));
      chk("WAKE",         32'(bus.WAKE), 32'(m_wake));
    end
  end

  always @(posedge clk) begin
    #2;
    if (bus.WAKE === 1'b1) wake_cnt++;
  end

  task automatic wait_state(input int st, input int maxc, output int cnt);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (bus.STATE != 3'(st) && cnt < maxc);
    if (bus.STATE != 3'(st)) begin
      n_vec++; n_err++;
      $display("FAIL wait_state: state %0d not reached, got %0d after %0d cycles", st, bus.STATE, cnt);
    end
  endtask

  task automatic wait_wake(input int maxc, output int cnt);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (bus.WAKE !== 1'b1 && cnt < maxc);
    if (bus.WAKE !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL wait_wake: no WAKE within %0d cycles", maxc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; wake_cnt = 0; chk_on = 0;
    rst = 1'b0;
    bus.CLK_ENA = 1'b1; bus.OSC_ENA = 1'b1;
    bus.IRQ_PEND = '0; bus.IE = '0; bus.JOYP_N = 4'hF;
    #1 rst = 1'b1;
    chk_on = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Power-up: 4 hold + 16 warm-up cycles, then RUN with all three outputs flipping together
    wait_state(P_RUN, 100, n);
    chk("pwrup_latency", n, 20);
    chk("pwrup_sr", bus.SYNC_RESET, 0);
    chk("pwrup_os", bus.OSC_STABLE, 1);
    chk("pwrup_gate", bus.CPU_CLK_GATE, 1);

    // HALT, then IRQ wake
    bus.CLK_ENA = 1'b0; bus.IE = 5'h04;
    repeat (10) @(negedge clk);
    chk("halt_state", bus.STATE, P_HALT);
    chk("halt_gate", bus.CPU_CLK_GATE, 0);
    bus.IRQ_PEND = 5'h04;
    @(negedge clk);
    chk("halt_wake", bus.WAKE, 1);
    chk("halt_gate_on", bus.CPU_CLK_GATE, 1);
    bus.CLK_ENA = 1'b1; bus.IRQ_PEND = '0;
    @(negedge clk);
    chk("halt_wake_1cyc", bus.WAKE, 0);

    // STOP, joypad wake through the synchroniser
    bus.OSC_ENA = 1'b0; bus.CLK_ENA = 1'b0;
    @(negedge clk);
    chk("stop_state", bus.STATE, P_STOP);
    chk("stop_os", bus.OSC_STABLE, 0);
    repeat (3) @(negedge clk);
    bus.JOYP_N = 4'hE;
    wait_wake(10, n);
    chk("joy_wake_lat", n, 3);
    chk("joy_wake_state", bus.STATE, P_WARM);
    bus.JOYP_N = 4'hF; bus.OSC_ENA = 1'b1; bus.CLK_ENA = 1'b1;
    wait_state(P_RUN, 40, n);
    chk("stop_warm_len", n, 16);
    chk("stop_os_back", bus.OSC_STABLE, 1);

    // Wake ignored by the sequencer: back to STOP, single WAKE pulse
    bus.OSC_ENA = 1'b0;
    @(negedge clk);
    bus.IE = 5'h10;
    repeat (2) @(negedge clk);
    w0 = wake_cnt;
    bus.IRQ_PEND = 5'h10;
    wait_wake(5, n);
    chk("irq4_wake_lat", n, 1);
    bus.IRQ_PEND = '0;
    wait_state(P_STOP, 40, n);
    chk("ignored_warm_len", n, 16);
    chk("ignored_wake_cnt", wake_cnt - w0, 1);

    // Back to RUN, then IRQ pending at HALT entry -> one HALT cycle
    bus.OSC_ENA = 1'b1; bus.IRQ_PEND = 5'h10;
    wait_wake(5, n);
    bus.IRQ_PEND = '0;
    wait_state(P_RUN, 40, n);
    chk("rerun_len", n, 16);
    bus.IE = 5'h04; bus.IRQ_PEND = 5'h04; bus.CLK_ENA = 1'b0;
    @(negedge clk);
    chk("entry_halt", bus.STATE, P_HALT);
    @(negedge clk);
    chk("entry_run", bus.STATE, P_RUN);
    chk("entry_wake", bus.WAKE, 1);
    bus.CLK_ENA = 1'b1; bus.IRQ_PEND = '0;
    w0 = wake_cnt;
    bus.JOYP_N = 4'h0;
    repeat (5) @(negedge clk);
    bus.CLK_ENA = 1'b0;
    repeat (5) @(negedge clk);
    chk("joy_halt_state", bus.STATE, P_HALT);
    bus.CLK_ENA = 1'b1;
    @(negedge clk);
    chk("clkena_resume", bus.STATE, P_RUN);
    chk("clkena_no_wake", bus.WAKE, 0);
    repeat (3) @(negedge clk);
    bus.JOYP_N = 4'hF;
    chk("joy_no_wake", wake_cnt - w0, 0);

    // Reset in the middle of a post-STOP warm-up (cnt = 7)
    bus.OSC_ENA = 1'b0;
    @(negedge clk);
    bus.JOYP_N = 4'hE;
    wait_wake(10, n);
    bus.JOYP_N = 4'hF; bus.OSC_ENA = 1'b1;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_state", bus.STATE, P_HOLD);
    chk("async_sr", bus.SYNC_RESET, 1);
    chk("async_os", bus.OSC_STABLE, 0);
    chk("async_gate", bus.CPU_CLK_GATE, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_state(P_RUN, 100, n);
    chk("replay_latency", n, 20);

    // Random traffic checked cycle by cycle against the model
    repeat (3000) begin
      @(negedge clk);
      bus.OSC_ENA  = ($urandom_range(0, 19) != 0);
      bus.CLK_ENA  = ($urandom_range(0, 9) != 0);
      bus.IE       = 5'($urandom);
      bus.IRQ_PEND = ($urandom_range(0, 15) == 0) ? 5'($urandom) : 5'h00;
      bus.JOYP_N   = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
